// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, reads the instruction memory, and buffers words in a 2-entry FIFO for decode.
// Optional FETCH_PERF_CNT_EN adds saturating perf_fetched / perf_stall counters.
module fetch_controller #(
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            INSTR_WIDTH = 32,
  parameter int unsigned            MEM_DEPTH   = 512,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_instr,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [INSTR_WIDTH-1:0] inst_out,
  output logic [ADDR_WIDTH-1:0]  inst_pc,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   fault,
  output logic [ADDR_WIDTH-1:0]  fault_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_stall
`endif
);

  localparam int unsigned         FIFO_DEPTH = 2;
  localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_DEPTH);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   pc;
  logic [INSTR_WIDTH-1:0]  fifo_instr [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   fifo_pc    [FIFO_DEPTH];
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [1:0]              count;

  logic                    full;
  logic                    pop;
  logic                    flush;
  logic                    fetch_slot;
  logic                    in_range;
  logic                    push;

  // Word index is a pure re-wiring of the PC register.
  assign imem_addr = {2'b00, pc[ADDR_WIDTH-1:2]};

  assign inst_valid = (count != 2'd0);
  assign inst_out   = fifo_instr[rd_ptr];
  assign inst_pc    = fifo_pc[rd_ptr];

  // Redirect outranks fetching; a fetch slot exists when there is room or the head leaves this cycle.
  always_comb begin
    full       = (count == 2'(FIFO_DEPTH));
    pop        = inst_valid && inst_ready;
    flush      = (state == FETCH) && redirect_valid;
    fetch_slot = (state == FETCH) && !redirect_valid && (!full || pop);
    in_range   = (imem_addr < MEM_LIMIT);
    push       = fetch_slot && in_range;
  end

  // Sequencer state, PC and fault capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      fault    <= 1'b0;
      fault_pc <= '0;
    end else begin
      case (state)
        BOOT: begin
          state <= FETCH;
        end
        FETCH: begin
          if (redirect_valid) begin
            if (redirect_pc[1:0] == 2'b00) begin
              pc <= redirect_pc;
            end else begin
              fault    <= 1'b1;
              fault_pc <= redirect_pc;
              state    <= HALT;
            end
          end else if (fetch_slot) begin
            if (in_range) begin
              pc <= pc + ADDR_WIDTH'(4);
            end else begin
              fault    <= 1'b1;
              fault_pc <= pc;
              state    <= HALT;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

  // Two-entry FIFO; flush drops contents and any concurrent pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_instr[wr_ptr] <= imem_instr;
        fifo_pc[wr_ptr]    <= pc;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic stall;

  assign stall = (state == FETCH) && !redirect_valid && full && !pop;

  // Saturating counters; they only advance while fetching, so HALT freezes them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (push && (perf_fetched != 32'hFFFF_FFFF)) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (stall && (perf_stall != 32'hFFFF_FFFF)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed self-checking bench for fetch_controller: startup, stall, redirect, misalign fault, range fault, mid-stream reset.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fault;
  logic [31:0] fault_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  logic [31:0] mem [512];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  fetch_controller dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fault          (fault),
    .fault_pc       (fault_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  assign imem_instr = (imem_addr < 32'd512) ? mem[imem_addr[8:0]] : 32'hDEAD_BEEF;

  // Memory image: two R-type words, then "addi x0,x0,i" tagged by word index.
  function automatic logic [31:0] word(int i);
    if (i == 0) return 32'h0041_82b3;
    if (i == 1) return 32'h4041_8333;
    return 32'h0000_0013 | (32'(i) << 20);
  endfunction

  task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds reset across one edge and releases it just after, so the next edge is the BOOT cycle.
  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = word(i);

    // Startup with decode always ready.
    #1;
    reset = 1'b1;
    inst_ready = 1'b1;
    step(2);
    check("rst_valid", 64'(inst_valid), 64'd0);
    check("rst_out", 64'(inst_out), 64'd0);
    check("rst_pc", 64'(inst_pc), 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    check("rst_fault_pc", 64'(fault_pc), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);
    reset = 1'b0;
    step(1);
    check("boot_valid", 64'(inst_valid), 64'd0);
    step(1);
    check("first_valid", 64'(inst_valid), 64'd1);
    check("first_out", 64'(inst_out), 64'h0041_82b3);
    check("first_pc", 64'(inst_pc), 64'd0);
    check("first_addr", 64'(imem_addr), 64'd1);
    step(1);
    check("second_out", 64'(inst_out), 64'h4041_8333);
    check("second_pc", 64'(inst_pc), 64'd4);
    step(1);
    check("third_valid", 64'(inst_valid), 64'd1);
    check("third_pc", 64'(inst_pc), 64'd8);
    check("third_out", 64'(inst_out), 64'(word(2)));

    // Backpressure: FIFO fills with pcs 0 and 4, pc parks at 8.
    inst_ready = 1'b0;
    do_reset();
    step(5);
    check("stall_valid", 64'(inst_valid), 64'd1);
    check("stall_head", 64'(inst_pc), 64'd0);
    check("stall_addr", 64'(imem_addr), 64'd2);
    inst_ready = 1'b1;
    step(1);
    check("drain_pc4", 64'(inst_pc), 64'd4);
    step(1);
    check("drain_pc8", 64'(inst_pc), 64'd8);
    check("drain_out8", 64'(inst_out), 64'(word(2)));
    step(1);
    check("drain_pc12", 64'(inst_pc), 64'd12);

    // Redirect to 0x20 with a full FIFO; same-cycle pop is dropped.
    inst_ready = 1'b0;
    do_reset();
    step(3);
    check("pre_redir_full", 64'(inst_valid), 64'd1);
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h20;
    step(1);
    redirect_valid = 1'b0;
    check("redir_flush", 64'(inst_valid), 64'd0);
    check("redir_addr", 64'(imem_addr), 64'd8);
    step(1);
    check("redir_valid", 64'(inst_valid), 64'd1);
    check("redir_pc", 64'(inst_pc), 64'h20);
    check("redir_out", 64'(inst_out), 64'(word(8)));
    check("redir_nofault", 64'(fault), 64'd0);

    // Misaligned redirect halts; later redirects are ignored.
    redirect_valid = 1'b1;
    redirect_pc = 32'h22;
    step(1);
    redirect_valid = 1'b0;
    check("mis_fault", 64'(fault), 64'd1);
    check("mis_fault_pc", 64'(fault_pc), 64'h22);
    check("mis_valid", 64'(inst_valid), 64'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    step(1);
    redirect_valid = 1'b0;
    step(3);
    check("halt_valid", 64'(inst_valid), 64'd0);
    check("halt_addr", 64'(imem_addr), 64'd9);
    check("halt_fault_pc", 64'(fault_pc), 64'h22);

    // Range fault at word 512; redirect during BOOT is ignored.
    inst_ready = 1'b1;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'h7F8;
    step(1);
    check("boot_redir_ign", 64'(imem_addr), 64'd0);
    step(1);
    redirect_valid = 1'b0;
    check("rng_redir_addr", 64'(imem_addr), 64'h1FE);
    check("rng_redir_valid", 64'(inst_valid), 64'd0);
    step(1);
    check("rng_pc7f8", 64'(inst_pc), 64'h7F8);
    step(1);
    check("rng_pc7fc", 64'(inst_pc), 64'h7FC);
    check("rng_out511", 64'(inst_out), 64'(word(511)));
    check("rng_nofault", 64'(fault), 64'd0);
    step(1);
    check("rng_fault", 64'(fault), 64'd1);
    check("rng_fault_pc", 64'(fault_pc), 64'h800);
    check("rng_nopush", 64'(inst_valid), 64'd0);

    // Mid-stream asynchronous reset with a full FIFO.
    inst_ready = 1'b0;
    do_reset();
    step(4);
    check("mid_full", 64'(inst_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_valid", 64'(inst_valid), 64'd0);
    check("async_fault", 64'(fault), 64'd0);
    check("async_addr", 64'(imem_addr), 64'd0);
    check("async_out", 64'(inst_out), 64'd0);
    step(1);
    reset = 1'b0;
    inst_ready = 1'b1;
    step(2);
    check("restart_valid", 64'(inst_valid), 64'd1);
    check("restart_pc", 64'(inst_pc), 64'd0);
    check("restart_out", 64'(inst_out), 64'h0041_82b3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
